// File: rtl/iu_pkg.sv
// Shared types and instruction field helpers
// for the program-sequencing instruction unit.
package iu_pkg;

  localparam int IU_MAXW = 64;

  typedef logic [IU_MAXW-1:0] iu_word_t;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_ADD   = 4'd1,
    OP_AND   = 4'd2,
    OP_XOR   = 4'd3,
    OP_MUL   = 4'd4,
    OP_LOAD  = 4'd8,
    OP_STORE = 4'd9,
    OP_HALT  = 4'd15
  } iu_opcode_t;

  typedef enum logic [2:0] {
    IU_IDLE,
    IU_FETCH,
    IU_DECODE,
    IU_MEM_WAIT,
    IU_ALU_WAIT,
    IU_HALTED
  } iu_state_t;

  typedef enum logic [2:0] {
    ALU_NOP = 3'd0,
    ALU_ADD = 3'd1,
    ALU_AND = 3'd2,
    ALU_XOR = 3'd3,
    ALU_MUL = 3'd4
  } alu_op_t;

  function automatic iu_word_t iu_mask(input int rw);
    return (iu_word_t'(1) << rw) - iu_word_t'(1);
  endfunction

  function automatic logic [3:0] iu_opc(
    input iu_word_t w,
    input int       iw
  );
    iu_word_t s;
    s = w >> (iw - 4);
    return s[3:0];
  endfunction

  function automatic iu_word_t iu_addr(
    input iu_word_t w,
    input int       rw
  );
    return w >> (2 * rw);
  endfunction

  function automatic iu_word_t iu_ra(
    input iu_word_t w,
    input int       rw
  );
    return (w >> rw) & iu_mask(rw);
  endfunction

  function automatic iu_word_t iu_rb(
    input iu_word_t w,
    input int       rw
  );
    return w & iu_mask(rw);
  endfunction

endpackage

// File: rtl/iu_instr_mem.sv
// Instruction store: one write port,
// one synchronous read port.
module iu_instr_mem #(
  parameter int DEPTH = 1024,
  parameter int W     = 22,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];

  // write port and registered read port
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata <= mem_q[raddr];
  end

endmodule

// File: rtl/instr_unit_seq.sv
// Program sequencer: fetches from local instruction
// memory, drives MIU and ALU handshakes.
module instr_unit_seq
  import iu_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 14,
  parameter int DEPTH   = 1024,
  parameter int NREGS   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [4+ADDR_W+2*$clog2(NREGS)-1:0] prog_data,
  input  logic                     run,
  output logic                     mem_load,
  output logic                     mem_store,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [2*DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_done,
  output logic                     alu_start,
  output logic [2:0]               alu_op,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  input  logic                     alu_done,
  input  logic [2*DATA_W-1:0]      alu_result,
  output logic                     busy,
  output logic                     halted,
  output logic                     error,
  output logic [$clog2(DEPTH)-1:0] pc
);

  localparam int RW      = $clog2(NREGS);
  localparam int PW      = $clog2(DEPTH);
  localparam int INSTR_W = 4 + ADDR_W + 2 * RW;
  localparam int CW      = $clog2(TIMEOUT + 1);

  iu_state_t state_q, state_d;

  logic [INSTR_W-1:0]  ir;
  logic [PW-1:0]       pc_q;
  logic [DATA_W-1:0]   rf_q [NREGS];
  logic [2*DATA_W-1:0] res_q;
  logic                err_q;
  logic [CW-1:0]       cnt_q;

  iu_word_t    iw;
  iu_opcode_t  op;
  logic [ADDR_W-1:0] f_addr;
  logic [RW-1:0]     f_ra;
  logic [RW-1:0]     f_rb;

  logic go, adv, fault, ld_we, res_we;
  logic last, tmo, in_wait;

  iu_instr_mem #(
    .DEPTH (DEPTH),
    .W     (INSTR_W),
    .AW    (PW)
  ) u_imem (
    .clk   (clk),
    .we    (prog_we && !busy),
    .waddr (prog_addr),
    .wdata (prog_data),
    .re    (state_q == IU_FETCH),
    .raddr (pc_q),
    .rdata (ir)
  );

  assign iw     = iu_word_t'(ir);
  assign op     = iu_opcode_t'(iu_opc(iw, INSTR_W));
  assign f_addr = ADDR_W'(iu_addr(iw, RW));
  assign f_ra   = RW'(iu_ra(iw, RW));
  assign f_rb   = RW'(iu_rb(iw, RW));

  assign last    = (pc_q == PW'(DEPTH - 1));
  assign tmo     = (cnt_q == CW'(TIMEOUT - 1));
  assign in_wait = (state_q == IU_MEM_WAIT) ||
                   (state_q == IU_ALU_WAIT);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IU_IDLE;
    else       state_q <= state_d;
  end

  // next state and datapath strobes
  always_comb begin
    state_d = state_q;
    go      = 1'b0;
    adv     = 1'b0;
    fault   = 1'b0;
    ld_we   = 1'b0;
    res_we  = 1'b0;
    unique case (state_q)
      IU_IDLE, IU_HALTED: begin
        if (run) begin
          state_d = IU_FETCH;
          go      = 1'b1;
        end
      end
      IU_FETCH: state_d = IU_DECODE;
      IU_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE:
            state_d = IU_MEM_WAIT;
          OP_ADD, OP_AND, OP_XOR, OP_MUL:
            state_d = IU_ALU_WAIT;
          OP_NOP:  adv = 1'b1;
          OP_HALT: state_d = IU_HALTED;
          default: begin
            fault   = 1'b1;
            state_d = IU_HALTED;
          end
        endcase
      end
      IU_MEM_WAIT: begin
        if (mem_done) begin
          adv   = 1'b1;
          ld_we = (op == OP_LOAD);
        end else if (tmo) begin
          fault   = 1'b1;
          state_d = IU_HALTED;
        end
      end
      IU_ALU_WAIT: begin
        if (alu_done) begin
          adv    = 1'b1;
          res_we = 1'b1;
        end else if (tmo) begin
          fault   = 1'b1;
          state_d = IU_HALTED;
        end
      end
      default: state_d = IU_IDLE;
    endcase
    if (adv) state_d = last ? IU_HALTED : IU_FETCH;
  end

  // outputs decoded from state, so reset drops them at once
  always_comb begin
    mem_load  = 1'b0;
    mem_store = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    alu_start = 1'b0;
    alu_op    = '0;
    alu_a     = '0;
    alu_b     = '0;
    busy      = 1'b0;
    halted    = 1'b0;
    unique case (1'b1)
      (state_q == IU_MEM_WAIT): begin
        busy      = 1'b1;
        mem_load  = (op == OP_LOAD);
        mem_store = (op == OP_STORE);
        mem_addr  = f_addr;
        if (op == OP_STORE) mem_wdata = res_q;
      end
      (state_q == IU_ALU_WAIT): begin
        busy      = 1'b1;
        alu_start = 1'b1;
        alu_op    = alu_op_t'(op[2:0]);
        alu_a     = rf_q[f_ra];
        alu_b     = rf_q[f_rb];
      end
      (state_q == IU_FETCH),
      (state_q == IU_DECODE): busy = 1'b1;
      (state_q == IU_HALTED): halted = 1'b1;
      default: ;
    endcase
  end

  assign pc    = pc_q;
  assign error = err_q;

  // pc, error, timeout counter, register file, result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
      res_q <= '0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      if (go) begin
        pc_q  <= '0;
        err_q <= 1'b0;
      end else if (adv && !last) begin
        pc_q <= pc_q + 1'b1;
      end
      if (fault) err_q <= 1'b1;
      if (in_wait) cnt_q <= cnt_q + 1'b1;
      else         cnt_q <= '0;
      if (ld_we)  rf_q[f_ra] <= mem_rdata;
      if (res_we) res_q <= alu_result;
    end
  end

endmodule

// File: tb/tb_instr_unit_seq.sv
// Scoreboard bench for instr_unit_seq with
// behavioural MIU and ALU responders.
module tb_instr_unit_seq;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 14;
  localparam int DEPTH  = 16;
  localparam int NREGS  = 4;
  localparam int IW     = 4 + ADDR_W + 4;

  logic              clk = 0;
  logic              reset;
  logic              prog_we;
  logic [3:0]        prog_addr;
  logic [IW-1:0]     prog_data;
  logic              run;
  logic              mem_load, mem_store;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_done;
  logic              alu_start;
  logic [2:0]        alu_op;
  logic [7:0]        alu_a, alu_b;
  logic              alu_done;
  logic [15:0]       alu_result;
  logic              busy, halted, error;
  logic [3:0]        pc;

  instr_unit_seq #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .NREGS   (NREGS),
    .TIMEOUT (255)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .run        (run),
    .mem_load   (mem_load),
    .mem_store  (mem_store),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_done   (mem_done),
    .alu_start  (alu_start),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .busy       (busy),
    .halted     (halted),
    .error      (error),
    .pc         (pc)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] sb [$];
  logic [IW-1:0] prog [16];

  int mlat = 3;
  int alat = 4;
  bit miu_dead = 0;
  int m_cnt = 0, a_cnt = 0;
  int m_run = 0, a_run = 0;
  int mem_len = 0, alu_len = 0;
  logic ml_p = 0, ms_p = 0, as_p = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [IW-1:0] enc(
    input logic [3:0] op, input logic [13:0] a,
    input logic [1:0] ra, input logic [1:0] rb);
    return {op, a, ra, rb};
  endfunction

  function automatic logic [31:0] ev_mem(
    input logic [1:0] k, input logic [13:0] a,
    input logic [15:0] d);
    return {k, a, d};
  endfunction

  function automatic logic [31:0] ev_alu(
    input logic [2:0] op, input logic [7:0] a,
    input logic [7:0] b);
    return {2'd3, 11'd0, op, a, b};
  endfunction

  function automatic logic [7:0] miu_rd(
    input logic [13:0] a);
    case (a)
      14'h10:  return 8'h05;
      14'h11:  return 8'h07;
      14'h20:  return 8'hFF;
      14'h21:  return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [15:0] alu_f(
    input logic [2:0] op, input logic [7:0] a,
    input logic [7:0] b);
    case (op)
      3'd1:    return {8'd0, a} + {8'd0, b};
      3'd2:    return {8'd0, a & b};
      3'd3:    return {8'd0, a ^ b};
      3'd4:    return a * b;
      default: return 16'd0;
    endcase
  endfunction

  task automatic sb_cmp(input logic [31:0] ev);
    logic [31:0] e;
    if (sb.size() == 0) begin
      chk("sb_extra", ev, 32'h0);
    end else begin
      e = sb.pop_front();
      chk("sb_req", ev, e);
    end
  endtask

  // MIU responder: done on the mlat-th request cycle
  always @(negedge clk) begin
    if (mem_load || mem_store) begin
      m_cnt++;
      mem_done  = !miu_dead && (m_cnt == mlat);
      mem_rdata = miu_rd(mem_addr);
    end else begin
      m_cnt    = 0;
      mem_done = 0;
    end
  end

  // ALU responder: done on the alat-th start cycle
  always @(negedge clk) begin
    if (alu_start) begin
      a_cnt++;
      alu_done   = (a_cnt == alat);
      alu_result = alu_f(alu_op, alu_a, alu_b);
    end else begin
      a_cnt    = 0;
      alu_done = 0;
    end
  end

  // request monitor: scoreboard and hold lengths
  always @(negedge clk) begin
    if (mem_load && !ml_p)
      sb_cmp(ev_mem(2'd1, mem_addr, 16'd0));
    if (mem_store && !ms_p)
      sb_cmp(ev_mem(2'd2, mem_addr, mem_wdata));
    if (alu_start && !as_p)
      sb_cmp(ev_alu(alu_op, alu_a, alu_b));
    if (mem_load || mem_store) m_run++;
    else begin
      if (m_run != 0) mem_len = m_run;
      m_run = 0;
    end
    if (alu_start) a_run++;
    else begin
      if (a_run != 0) alu_len = a_run;
      a_run = 0;
    end
    ml_p = mem_load;
    ms_p = mem_store;
    as_p = alu_start;
  end

  task automatic write_prog();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      prog_we   = 1;
      prog_addr = 4'(i);
      prog_data = prog[i];
    end
    @(negedge clk);
    prog_we = 0;
  endtask

  task automatic pulse_run();
    @(negedge clk);
    run = 1;
    @(negedge clk);
    run = 0;
  endtask

  task automatic wait_halt(input int maxc);
    bit seen = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (halted) begin
        seen = 1;
        break;
      end
    end
    if (!seen) chk("wait_halt", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic fill(input logic [IW-1:0] w);
    for (int i = 0; i < 16; i++) prog[i] = w;
  endtask

  initial begin
    bit seen;
    reset     = 1;
    prog_we   = 0;
    prog_addr = 0;
    prog_data = 0;
    run       = 0;
    mem_done  = 0;
    mem_rdata = 0;
    alu_done  = 0;
    alu_result = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_req", {29'd0, mem_load, mem_store, alu_start}, 0);
    reset = 0;

    // load/add/store program
    fill(enc(4'hF, 0, 0, 0));
    prog[0] = enc(4'h8, 14'h10, 2'd0, 2'd0);
    prog[1] = enc(4'h8, 14'h11, 2'd1, 2'd0);
    prog[2] = enc(4'h1, 14'h0, 2'd0, 2'd1);
    prog[3] = enc(4'h9, 14'h12, 2'd0, 2'd0);
    write_prog();
    sb.push_back(ev_mem(2'd1, 14'h10, 16'h0));
    sb.push_back(ev_mem(2'd1, 14'h11, 16'h0));
    sb.push_back(ev_alu(3'd1, 8'h05, 8'h07));
    sb.push_back(ev_mem(2'd2, 14'h12, 16'h000C));
    pulse_run();
    wait_halt(200);
    chk("t1_halted", 32'(halted), 1);
    chk("t1_error", 32'(error), 0);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_pc", 32'(pc), 4);
    chk("t1_memlen", 32'(mem_len), 3);
    chk("t1_drain", 32'(sb.size()), 0);

    // MUL 0xFF*0xFF, 4-cycle ALU
    fill(enc(4'hF, 0, 0, 0));
    prog[0] = enc(4'h8, 14'h20, 2'd2, 2'd0);
    prog[1] = enc(4'h8, 14'h21, 2'd3, 2'd0);
    prog[2] = enc(4'h4, 14'h0, 2'd2, 2'd3);
    prog[3] = enc(4'h9, 14'h30, 2'd0, 2'd0);
    write_prog();
    sb.push_back(ev_mem(2'd1, 14'h20, 16'h0));
    sb.push_back(ev_mem(2'd1, 14'h21, 16'h0));
    sb.push_back(ev_alu(3'd4, 8'hFF, 8'hFF));
    sb.push_back(ev_mem(2'd2, 14'h30, 16'hFE01));
    pulse_run();
    wait_halt(200);
    chk("t2_alulen", 32'(alu_len), 4);
    chk("t2_error", 32'(error), 0);
    chk("t2_drain", 32'(sb.size()), 0);

    // illegal opcode at pc=2
    fill(enc(4'h9, 14'h40, 0, 0));
    prog[0] = enc(4'h0, 0, 0, 0);
    prog[1] = enc(4'h0, 0, 0, 0);
    prog[2] = enc(4'h6, 14'h55, 2'd1, 2'd2);
    write_prog();
    pulse_run();
    wait_halt(100);
    chk("t3_error", 32'(error), 1);
    chk("t3_halted", 32'(halted), 1);
    chk("t3_pc", 32'(pc), 2);
    chk("t3_drain", 32'(sb.size()), 0);

    // MIU never completes
    miu_dead = 1;
    fill(enc(4'hF, 0, 0, 0));
    prog[0] = enc(4'h8, 14'h10, 2'd0, 2'd0);
    write_prog();
    sb.push_back(ev_mem(2'd1, 14'h10, 16'h0));
    pulse_run();
    chk("t4_errclr", 32'(error), 0);
    chk("t4_busy", 32'(busy), 1);
    wait_halt(400);
    chk("t4_memlen", 32'(mem_len), 255);
    chk("t4_error", 32'(error), 1);
    chk("t4_halted", 32'(halted), 1);
    chk("t4_load", 32'(mem_load), 0);
    chk("t4_drain", 32'(sb.size()), 0);
    miu_dead = 0;

    // reset while waiting on the ALU
    alat = 50;
    fill(enc(4'hF, 0, 0, 0));
    prog[0] = enc(4'h1, 0, 2'd0, 2'd1);
    write_prog();
    sb.push_back(ev_alu(3'd1, 8'h05, 8'h07));
    pulse_run();
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (alu_start) begin
        seen = 1;
        break;
      end
    end
    chk("t5_start", 32'(seen), 1);
    repeat (2) @(negedge clk);
    #2 reset = 1;
    #1;
    chk("t5_aluoff", 32'(alu_start), 0);
    chk("t5_busyoff", 32'(busy), 0);
    @(negedge clk);
    reset = 0;
    alat = 2;
    // write and run in the same IDLE cycle
    sb.push_back(ev_alu(3'd3, 8'h00, 8'h00));
    @(negedge clk);
    prog_we   = 1;
    prog_addr = 0;
    prog_data = enc(4'h3, 0, 2'd0, 2'd1);
    run       = 1;
    @(negedge clk);
    prog_we = 0;
    run     = 0;
    chk("t5_pc0", 32'(pc), 0);
    chk("t5_busy", 32'(busy), 1);
    wait_halt(100);
    chk("t5_error", 32'(error), 0);
    chk("t5_pc", 32'(pc), 1);
    chk("t5_drain", 32'(sb.size()), 0);

    // all NOPs: run off the end, writes ignored while busy
    fill(enc(4'h0, 0, 0, 0));
    write_prog();
    pulse_run();
    @(negedge clk);
    prog_we   = 1;
    prog_addr = 4'd10;
    prog_data = enc(4'hF, 0, 0, 0);
    @(negedge clk);
    prog_we = 0;
    wait_halt(200);
    chk("t6_pc", 32'(pc), 15);
    chk("t6_halted", 32'(halted), 1);
    chk("t6_error", 32'(error), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_drain", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
